// File: rtl/ddr4_cmd_sequencer.sv
// Closed-page DDR4 command sequencer: one request at a time, ACT -> RD/WR -> PRE,
// with registered command-bus outputs and data-window strobes.
module ddr4_cmd_sequencer #(
    parameter int BGWIDTH     = 2,
    parameter int BAWIDTH     = 2,
    parameter int ADDRWIDTH   = 17,
    parameter int COLWIDTH    = 10,
    parameter int BL          = 8,
    parameter int TRCD        = 15,
    parameter int TCL         = 15,
    parameter int TRP         = 15,
    parameter int INIT_CYCLES = 5
) (
    input  logic                                 ck_t,
    input  logic                                 reset_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [BGWIDTH-1:0]                   req_bg,
    input  logic [BAWIDTH-1:0]                   req_ba,
    input  logic [ADDRWIDTH-1:0]                 req_row,
    input  logic [COLWIDTH-1:0]                  req_col,
    output logic                                 cs_n,
    output logic                                 act_n,
    output logic [ADDRWIDTH-1:0]                 A,
    output logic [BGWIDTH-1:0]                   bg,
    output logic [BAWIDTH-1:0]                   ba,
    output logic                                 writing,
    output logic                                 rd_window,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]      sync,
    output logic                                 busy
);

    localparam int NBANK = 2**(BGWIDTH+BAWIDTH);

    typedef enum logic [3:0] {
        INIT, IDLE, ACT, RCD, CMD, BURST, CLWAIT, PRE, RP
    } state_t;

    state_t               state;
    logic [15:0]          cnt;
    logic                 lat_write;
    logic [COLWIDTH-1:0]  lat_col;

    function automatic logic [ADDRWIDTH-1:0] cas_addr(input logic rd,
                                                      input logic [COLWIDTH-1:0] col);
        logic [ADDRWIDTH-1:0] a;
        a = '0;
        a[COLWIDTH-1:0] = col;
        a[16:14] = rd ? 3'b101 : 3'b100;
        return a;
    endfunction

    function automatic logic [ADDRWIDTH-1:0] pre_addr();
        logic [ADDRWIDTH-1:0] a;
        a = '0;
        a[16:14] = 3'b010;
        return a;
    endfunction

    // Outputs are registered alongside the state, so every branch below drives
    // the values belonging to the state being entered, not the current one.
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_col   <= '0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            A         <= '0;
            bg        <= '0;
            ba        <= '0;
            writing   <= 1'b0;
            rd_window <= 1'b0;
            sync      <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            cs_n  <= 1'b1;
            act_n <= 1'b1;
            A     <= '0;
            case (state)
                INIT: begin
                    if (int'(cnt) + 1 >= INIT_CYCLES) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        state     <= ACT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        lat_write <= req_write;
                        lat_col   <= req_col;
                        cs_n      <= 1'b0;
                        act_n     <= 1'b0;
                        A         <= req_row;
                        bg        <= req_bg;
                        ba        <= req_ba;
                        sync      <= NBANK'(1) << {req_bg, req_ba};
                    end
                end
                ACT: begin
                    state <= RCD;
                    cnt   <= '0;
                end
                RCD: begin
                    if (int'(cnt) + 1 >= TRCD - 1) begin
                        state   <= CMD;
                        cs_n    <= 1'b0;
                        A       <= cas_addr(!lat_write, lat_col);
                        writing <= lat_write;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CMD: begin
                    cnt <= '0;
                    if (lat_write) begin
                        if (BL <= 1) begin
                            state   <= PRE;
                            cs_n    <= 1'b0;
                            A       <= pre_addr();
                            writing <= 1'b0;
                            sync    <= '0;
                        end else begin
                            state <= BURST;
                        end
                    end else if (TCL <= 1) begin
                        state     <= BURST;
                        rd_window <= 1'b1;
                    end else begin
                        state <= CLWAIT;
                    end
                end
                CLWAIT: begin
                    if (int'(cnt) + 1 >= TCL - 1) begin
                        state     <= BURST;
                        cnt       <= '0;
                        rd_window <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // Write bursts already spent one beat in CMD, reads spend all BL here.
                BURST: begin
                    if (int'(cnt) + 1 >= (lat_write ? BL - 1 : BL)) begin
                        state     <= PRE;
                        cs_n      <= 1'b0;
                        A         <= pre_addr();
                        writing   <= 1'b0;
                        rd_window <= 1'b0;
                        sync      <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PRE: begin
                    state <= RP;
                    cnt   <= '0;
                end
                RP: begin
                    if (int'(cnt) + 1 >= TRP) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        bg        <= '0;
                        ba        <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
